// File: rtl/camera_frame_writer.sv
// Packs camera bytes into 32-bit words, buffers them and streams them as sequential writes to the memory manager.
// Define FRAME_WRITER_BYTESWAP_EN to place the first byte of each word in [31:24] instead of [7:0].
//
// state     | meaning
// IDLE      | waiting for arm
// ARMED     | waiting for a vsync rising edge
// CAPTURE   | packing bytes and pushing words into the FIFO
// DRAIN     | all frame words pushed, emptying the FIFO
// DONE      | one-cycle frame_done pulse
module camera_frame_writer #(
    parameter logic [17:0] BASE_ADDRESS = 18'h0,
    parameter int          FRAME_WORDS  = 19200,
    parameter int          FIFO_AW      = 4
) (
    input  logic        clk_sync,
    input  logic        rst,
    input  logic        arm,
    input  logic        vsync,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    input  logic        pause,
    output logic        wren,
    output logic [31:0] data_write,
    output logic [17:0] starting_address,
    output logic        busy,
    output logic        frame_done,
    output logic        overflow
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = $clog2(FRAME_WORDS + 1);
    localparam logic [CW-1:0]      LAST_WORD = CW'(FRAME_WORDS - 1);
    localparam logic [FIFO_AW:0]   FULL_CNT  = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic               vsync_prev;
    logic               vsync_rise;
    logic [31:0]        pack;
    logic [31:0]        pack_nxt;
    logic [1:0]         byte_cnt;
    logic               word_ready;
    logic [CW-1:0]      word_cnt;
    logic [31:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   fifo_cnt;
    logic               fifo_empty;
    logic               fifo_full;
    logic               push;
    logic               pop;
    logic               byte_take;
    logic               last_push;
    logic               start_frame;

    assign vsync_rise  = vsync & ~vsync_prev;
    assign fifo_empty  = (fifo_cnt == '0);
    assign fifo_full   = (fifo_cnt == FULL_CNT);
    assign pop         = !pause && !fifo_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push        = word_ready && (!fifo_full || pop);
    assign last_push   = word_ready && (word_cnt == LAST_WORD);
    assign byte_take   = (state == S_CAPTURE) && byte_valid && !last_push;
    assign start_frame = (state == S_IDLE) && arm;

`ifdef FRAME_WRITER_BYTESWAP_EN
    assign pack_nxt = {pack[23:0], byte_in};
`else
    assign pack_nxt = {byte_in, pack[31:8]};
`endif

    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (arm) state_nxt = S_ARMED;
            end
            S_ARMED: begin
                busy = 1'b1;
                if (vsync_rise) state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                busy = 1'b1;
                if (last_push) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                // Leave once nothing is queued and the presented word (if any) is accepted now.
                if (fifo_empty && (!wren || !pause)) state_nxt = S_DONE;
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sync or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            vsync_prev <= 1'b0;
            pack       <= '0;
            byte_cnt   <= '0;
            word_ready <= 1'b0;
            word_cnt   <= '0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nxt;
            vsync_prev <= vsync;
            word_ready <= byte_take && (byte_cnt == 2'd3);
            if ((state == S_ARMED) && vsync_rise) begin
                byte_cnt <= '0;
            end else if (byte_take) begin
                pack     <= pack_nxt;
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (start_frame) begin
                word_cnt <= '0;
            end else if (word_ready) begin
                word_cnt <= word_cnt + CW'(1);
            end
            if (start_frame) begin
                overflow <= 1'b0;
            end else if (word_ready && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sync) begin
        if (push) mem[wr_ptr] <= pack;
    end

    always_ff @(posedge clk_sync or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (FIFO_AW + 1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (FIFO_AW + 1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // When idle, wren drops but address and data stay put so the manager sees no new traffic.
    always_ff @(posedge clk_sync or posedge rst) begin
        if (rst) begin
            wren             <= 1'b0;
            data_write       <= '0;
            starting_address <= BASE_ADDRESS;
        end else begin
            if (!pause) begin
                wren <= !fifo_empty;
                if (pop) data_write <= mem[rd_ptr];
            end
            if (start_frame) begin
                starting_address <= BASE_ADDRESS;
            end else if (wren && !pause) begin
                starting_address <= starting_address + 18'd1;
            end
        end
    end

endmodule

// File: tb/tb_camera_frame_writer.sv
// Scoreboard bench for camera_frame_writer: a byte-level frame model queues expected writes,
// a negedge monitor pops them as the DUT's writes are accepted.
module tb_camera_frame_writer;

    localparam logic [17:0] BASE  = 18'h3FFEC;
    localparam int          FW    = 20;
    localparam int          AW    = 4;
    localparam int          DEPTH = 16;

    logic        clk_sync = 1'b0;
    logic        rst = 1'b1;
    logic        arm = 1'b0;
    logic        vsync = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        pause = 1'b0;
    logic        wren;
    logic [31:0] data_write;
    logic [17:0] starting_address;
    logic        busy;
    logic        frame_done;
    logic        overflow;

    camera_frame_writer #(
        .BASE_ADDRESS(BASE),
        .FRAME_WORDS (FW),
        .FIFO_AW     (AW)
    ) dut (
        .clk_sync        (clk_sync),
        .rst             (rst),
        .arm             (arm),
        .vsync           (vsync),
        .byte_valid      (byte_valid),
        .byte_in         (byte_in),
        .pause           (pause),
        .wren            (wren),
        .data_write      (data_write),
        .starting_address(starting_address),
        .busy            (busy),
        .frame_done      (frame_done),
        .overflow        (overflow)
    );

    always #5 clk_sync = ~clk_sync;

    typedef struct packed {
        logic [17:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] grp[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int last_acc_cyc = -10;
    int first_wren_cyc = -1;
    int mdl_words = FW;
    int keep_limit = FW;
    bit mdl_armed = 1'b0;
    bit mdl_active = 1'b0;
    bit rand_pause = 1'b0;
    int pause_pct = 0;
    bit          prev_paused = 1'b0;
    logic        prev_wren;
    logic [31:0] prev_data;
    logic [17:0] prev_addr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack_word(input logic [7:0] b0, input logic [7:0] b1,
                                              input logic [7:0] b2, input logic [7:0] b3);
`ifdef FRAME_WRITER_BYTESWAP_EN
        return {b0, b1, b2, b3};
`else
        return {b3, b2, b1, b0};
`endif
    endfunction

    // Frame model: every 4 captured bytes make word k, written at BASE+k unless beyond keep_limit.
    function automatic void model_byte(input logic [7:0] b);
        wr_t e;
        if (!mdl_active || mdl_words >= FW) return;
        grp.push_back(b);
        if (grp.size() == 4) begin
            if (mdl_words < keep_limit) begin
                e.addr = BASE + 18'(mdl_words);
                e.data = pack_word(grp[0], grp[1], grp[2], grp[3]);
                exp_q.push_back(e);
            end
            mdl_words++;
            grp.delete();
        end
    endfunction

    always @(negedge clk_sync) begin
        wr_t e;
        cyc++;
        if (rst) begin
            prev_paused = 1'b0;
        end else begin
            if (prev_paused) begin
                chk("pause_hold_wren", 64'(wren), 64'(prev_wren));
                chk("pause_hold_data", 64'(data_write), 64'(prev_data));
                chk("pause_hold_addr", 64'(starting_address), 64'(prev_addr));
            end
            if (wren && first_wren_cyc < 0) first_wren_cyc = cyc;
            if (wren && !pause) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected no write", starting_address, data_write);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_addr", 64'(starting_address), 64'(e.addr));
                    chk("write_data", 64'(data_write), 64'(e.data));
                end
                last_acc_cyc = cyc;
            end
            if (frame_done) begin
                done_cnt++;
                chk("done_queue_empty", 64'(exp_q.size()), 64'd0);
                chk("done_after_accept", 64'(cyc), 64'(last_acc_cyc + 1));
                chk("done_busy_low", 64'(busy), 64'd0);
            end
            prev_paused = pause;
            prev_wren   = wren;
            prev_data   = data_write;
            prev_addr   = starting_address;
        end
    end

    task automatic tick();
        @(posedge clk_sync);
        #1;
        if (rand_pause) pause = ($urandom_range(0, 99) < pause_pct);
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_in    = b;
        model_byte(b);
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic send_random(input int n, input int gap_pct, input bit toggle_vsync);
        for (int i = 0; i < n; i++) begin
            if (toggle_vsync) vsync = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 99) < gap_pct) tick();
            send_byte(8'($urandom));
        end
        vsync = 1'b0;
    endtask

    task automatic do_arm();
        rand_pause = 1'b0;
        pause      = 1'b0;
        arm        = 1'b1;
        tick();
        arm            = 1'b0;
        mdl_armed      = 1'b1;
        mdl_active     = 1'b0;
        mdl_words      = 0;
        keep_limit     = FW;
        first_wren_cyc = -1;
        grp.delete();
    endtask

    task automatic do_vsync();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        tick();
        if (mdl_armed) mdl_active = 1'b1;
        mdl_armed = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < budget) begin
            tick();
            n++;
        end
        chk("frame_done_seen", 64'(done_cnt), 64'(start + 1));
        mdl_active = 1'b0;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish by t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int b4cyc;
        int n;
        int start;

        repeat (3) @(negedge clk_sync);
        chk("rst_wren", 64'(wren), 64'd0);
        chk("rst_data", 64'(data_write), 64'd0);
        chk("rst_addr", 64'(starting_address), 64'(BASE));
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        @(posedge clk_sync);
        #1 rst = 1'b0;
        tick();

        // Bytes and vsync before arm do nothing.
        do_vsync();
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        repeat (5) tick();
        chk("prearm_wren", 64'(wren), 64'd0);
        chk("prearm_addr", 64'(starting_address), 64'(BASE));
        chk("prearm_busy", 64'(busy), 64'd0);

        // Known 01..08 stream, junk bytes in ARMED, then the rest of the frame.
        do_arm();
        chk("arm_busy", 64'(busy), 64'd1);
        send_random(3, 0, 1'b0);
        do_vsync();
        b4cyc = 0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 4) b4cyc = cyc + 1;
            send_byte(8'(i));
        end
        send_random(4 * FW - 8, 20, 1'b0);
        wait_done(400);
        // 4th byte sampled at edge N, word presented from edge N+2.
        chk("first_word_latency", 64'(first_wren_cyc), 64'(b4cyc + 3));
        chk("frame1_overflow", 64'(overflow), 64'd0);

        // Traffic after the frame is ignored.
        do_vsync();
        send_random(8, 0, 1'b0);
        repeat (6) tick();
        chk("postdone_wren", 64'(wren), 64'd0);
        chk("postdone_busy", 64'(busy), 64'd0);

        // Pause held for 5 cycles while the first word is presented.
        do_arm();
        do_vsync();
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        n = 0;
        while (!wren && n < 10) begin
            tick();
            n++;
        end
        chk("pause_test_wren", 64'(wren), 64'd1);
        pause = 1'b1;
        for (int i = 5; i <= 8; i++) send_byte(8'(i));
        tick();
        pause = 1'b0;
        send_random(4 * FW - 8, 10, 1'b0);
        wait_done(400);

        // Random frames: random pause, gaps, stray vsync and a stray arm mid-frame.
        for (int f = 0; f < 3; f++) begin
            do_arm();
            do_vsync();
            rand_pause = 1'b1;
            pause_pct  = 30;
            send_random(2 * FW, 25, 1'b1);
            arm = 1'b1;
            tick();
            arm = 1'b0;
            send_random(2 * FW, 25, 1'b1);
            wait_done(1000);
            rand_pause = 1'b0;
            pause      = 1'b0;
            chk("random_overflow", 64'(overflow), 64'd0);
        end

        // Overflow: all frame words arrive while paused; only DEPTH survive.
        do_arm();
        do_vsync();
        keep_limit = DEPTH;
        pause = 1'b1;
        send_random(4 * FW, 0, 1'b0);
        repeat (3) tick();
        chk("ovf_set", 64'(overflow), 64'd1);
        chk("ovf_wren", 64'(wren), 64'd0);
        chk("ovf_busy", 64'(busy), 64'd1);
        chk("ovf_addr", 64'(starting_address), 64'(BASE));
        pause = 1'b0;
        wait_done(200);
        chk("ovf_sticky", 64'(overflow), 64'd1);
        do_arm();
        chk("ovf_cleared", 64'(overflow), 64'd0);

        // Async reset mid-capture.
        do_vsync();
        for (int i = 1; i <= 8; i++) send_byte(8'(8'h10 + i));
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk("pre_rst_drained", 64'(exp_q.size()), 64'd0);
        send_byte(8'hAA);
        send_byte(8'hBB);
        @(posedge clk_sync);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_wren", 64'(wren), 64'd0);
        chk("async_rst_data", 64'(data_write), 64'd0);
        chk("async_rst_addr", 64'(starting_address), 64'(BASE));
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_overflow", 64'(overflow), 64'd0);
        mdl_active = 1'b0;
        mdl_armed  = 1'b0;
        start = done_cnt;
        repeat (3) tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("no_done_after_rst", 64'(done_cnt), 64'(start));
        do_arm();
        do_vsync();
        send_random(4 * FW, 10, 1'b0);
        wait_done(400);

        chk("total_frames", 64'(done_cnt), 64'd7);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
